// File: rtl/sram_uart_transmitter_if.sv
// Handshake and SRAM/UART signal bundle for the SRAM-to-UART dump block.
// master = requester/SRAM side, slave = the transmitter itself.
interface sram_uart_transmitter_if #(
    parameter int ADDR_W = 18
);
    logic              Start;
    logic [ADDR_W-1:0] Start_address;
    logic [ADDR_W-1:0] Word_count;
    logic [ADDR_W-1:0] SRAM_address;
    logic [15:0]       SRAM_read_data;
    logic              SRAM_we_n;
    logic              UART_TX_O;
    logic              Busy;
    logic              Done;

    modport master (
        output Start, Start_address, Word_count, SRAM_read_data,
        input  SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
    );

    modport slave (
        input  Start, Start_address, Word_count, SRAM_read_data,
        output SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
    );
endinterface

// File: rtl/sram_uart_transmitter.sv
// Reads a block of 16-bit SRAM words and sends each as two 8N1 UART frames,
// high byte first.
//
// state      | meaning
// S_IDLE     | waiting for Start, line high
// S_READ     | present word address to SRAM for one cycle
// S_WAIT     | hold address until read data is valid, then capture it
// S_TX_START | start bit (low)
// S_TX_DATA  | 8 data bits, LSB first
// S_TX_STOP  | stop bit (high), then next byte / next word / finish
// S_DONE     | one-cycle completion pulse
module sram_uart_transmitter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_W       = 18
) (
    input  logic Clock_50,
    input  logic Reset,
    sram_uart_transmitter_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + READ_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_TX_START, S_TX_DATA, S_TX_STOP, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] words_left_q, words_left_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]       word_buf_q, word_buf_d;
    logic [7:0]        shift_q, shift_d;
    logic              byte_sel_q, byte_sel_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bit_end, wait_end;

    assign bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign wait_end = (cnt_q == CNT_W'(READ_LATENCY - 1));

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            sram_addr_q  <= '0;
            word_buf_q   <= '0;
            shift_q      <= '0;
            byte_sel_q   <= 1'b0;
            bit_cnt_q    <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            sram_addr_q  <= sram_addr_d;
            word_buf_q   <= word_buf_d;
            shift_q      <= shift_d;
            byte_sel_q   <= byte_sel_d;
            bit_cnt_q    <= bit_cnt_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        sram_addr_d  = sram_addr_q;
        word_buf_d   = word_buf_q;
        shift_d      = shift_q;
        byte_sel_d   = byte_sel_q;
        bit_cnt_d    = bit_cnt_q;
        cnt_d        = cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.Start) begin
                    addr_d       = bus.Start_address;
                    words_left_d = bus.Word_count;
                    state_d      = (bus.Word_count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                // Registered copy keeps the address stable through S_WAIT and beyond.
                sram_addr_d = addr_q;
                cnt_d       = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (wait_end) begin
                    word_buf_d = bus.SRAM_read_data;
                    byte_sel_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_TX_START;
                end
            end
            S_TX_START: begin
                shift_d = byte_sel_q ? word_buf_q[7:0] : word_buf_q[15:8];
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_TX_DATA;
                end
            end
            S_TX_DATA: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_TX_STOP;
                end
            end
            S_TX_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        state_d    = S_TX_START;
                    end else if (words_left_q > ADDR_W'(1)) begin
                        words_left_d = words_left_q - ADDR_W'(1);
                        addr_d       = addr_q + ADDR_W'(1);
                        state_d      = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.SRAM_address = (state_q == S_READ) ? addr_q : sram_addr_q;
    assign bus.SRAM_we_n    = 1'b1;
    assign bus.UART_TX_O    = (state_q == S_TX_START) ? 1'b0 :
                              (state_q == S_TX_DATA)  ? shift_q[0] : 1'b1;
    assign bus.Busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.Done         = (state_q == S_DONE);
endmodule

// File: tb/tb_sram_uart_transmitter.sv
// Randomised and directed checks of the SRAM-to-UART dump block against a
// timeline model of the serial line, plus an independent UART byte decoder.
module tb_sram_uart_transmitter;
    localparam int CPB = 434;
    localparam int RL  = 2;
    localparam int P   = 1 + RL + 20 * CPB;

    logic clk, rst;
    int   checks, errors;
    int   cyc;

    sram_uart_transmitter_if #(.ADDR_W(18)) bus ();

    sram_uart_transmitter #(.CLKS_PER_BIT(CPB), .READ_LATENCY(RL), .ADDR_W(18)) dut (
        .Clock_50(clk),
        .Reset   (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: data valid RL edges after the address is presented.
    logic [15:0] mem [0:(1<<18)-1];
    logic [17:0] a1, a2;
    always @(posedge clk) begin
        a1 <= bus.SRAM_address;
        a2 <= a1;
    end
    assign bus.SRAM_read_data = mem[a2];

    always @(posedge clk)
        assert (bus.SRAM_we_n === 1'b1)
        else $display("FAIL we_n_assert actual=%b expected=1", bus.SRAM_we_n);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model of the current transfer.
    logic        m_active, m_addr0;
    int          t0, m_n;
    logic [17:0] m_sa;
    logic [15:0] m_data [0:3];

    function automatic void model(input int k, output logic tx, output logic busy,
                                  output logic done, output logic av, output logic [17:0] addr);
        int w, o, f, p;
        logic [7:0] by;
        tx = 1'b1; busy = 1'b0; done = 1'b0; av = 1'b0; addr = '0;
        if (k >= 1 && k <= m_n * P) begin
            busy = 1'b1;
            w = (k - 1) / P;
            o = (k - 1) % P;
            if (o < 1 + RL) begin
                av   = 1'b1;
                addr = m_sa + 18'(w);
            end else begin
                f  = o - 1 - RL;
                by = (f / (10 * CPB) == 0) ? m_data[w][15:8] : m_data[w][7:0];
                p  = (f % (10 * CPB)) / CPB;
                if (p == 0) tx = 1'b0;
                else if (p <= 8) tx = by[p-1];
            end
        end
        done = (k >= 1) && (k == m_n * P + 1);
    endfunction

    always @(negedge clk) begin
        int k;
        logic etx, eb, ed, av;
        logic [17:0] ea;
        k = m_active ? cyc - t0 : 0;
        model(k, etx, eb, ed, av, ea);
        chk("tx_line", bus.UART_TX_O, etx);
        chk("busy", bus.Busy, eb);
        chk("done", bus.Done, ed);
        chk("we_n", bus.SRAM_we_n, 1);
        if (av) chk("sram_addr", bus.SRAM_address, ea);
        if (m_addr0) chk("addr_stays_zero", bus.SRAM_address, 0);
    end

    // Independent UART receiver, samples mid-bit.
    logic [7:0] rx_q [$];
    logic [7:0] rx_byte;
    logic       rx_busy, rx_prev;
    int         rx_cnt;
    initial begin rx_busy = 1'b0; rx_prev = 1'b1; rx_cnt = 0; rx_byte = '0; end
    always @(negedge clk) begin
        int j;
        if (rst) begin
            rx_busy = 1'b0;
            rx_prev = 1'b1;
        end else begin
            if (!rx_busy) begin
                if (rx_prev && !bus.UART_TX_O) begin
                    rx_busy = 1'b1;
                    rx_cnt  = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % CPB == CPB / 2) begin
                    j = rx_cnt / CPB;
                    if (j >= 1 && j <= 8) rx_byte[j-1] = bus.UART_TX_O;
                    else if (j == 9) begin
                        chk("stop_bit", bus.UART_TX_O, 1);
                        rx_q.push_back(rx_byte);
                        rx_busy = 1'b0;
                    end
                end
            end
            rx_prev = bus.UART_TX_O;
        end
    end

    logic [7:0] exp_b [$];

    task automatic check_bytes(input string nm, input int base);
        chk({nm, "_nbytes"}, rx_q.size() - base, exp_b.size());
        for (int i = 0; i < exp_b.size(); i++)
            if (base + i < rx_q.size()) chk({nm, "_byte"}, rx_q[base+i], exp_b[i]);
        exp_b.delete();
    endtask

    task automatic prepare(input logic [17:0] sa, input int n);
        m_sa = sa;
        m_n  = n;
        for (int i = 0; i < n; i++) m_data[i] = mem[sa + 18'(i)];
    endtask

    task automatic start_xfer(input logic [17:0] sa, input int n);
        @(posedge clk); #1;
        prepare(sa, n);
        m_active          = 1'b1;
        t0                = cyc;
        bus.Start         = 1'b1;
        bus.Start_address = sa;
        bus.Word_count    = 18'(n);
        @(posedge clk); #1;
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int dur);
        dur = -1;
        for (int i = 0; i < lim; i++) begin
            if (bus.Done === 1'b1) begin
                dur = cyc - t0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    int          base, dur, n;
    logic [17:0] sa;
    logic [15:0] d;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        bus.Start = 1'b0; bus.Start_address = '0; bus.Word_count = '0;
        m_active = 1'b0; m_addr0 = 1'b0; t0 = 0; m_n = 0; m_sa = '0;
        for (int i = 0; i < 4; i++) m_data[i] = '0;
        mem[18'h00005] = 16'hA55A;
        mem[18'h3FFFE] = 16'h0102;
        mem[18'h3FFFF] = 16'h0304;
        mem[18'h00000] = 16'h0506;

        repeat (3) @(posedge clk); #1;
        chk("rst_tx", bus.UART_TX_O, 1);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_addr", bus.SRAM_address, 0);
        chk("rst_we_n", bus.SRAM_we_n, 1);
        rst = 1'b0;

        // Zero words, then a Start held through Done, then a new transfer right after.
        @(posedge clk); #1;
        prepare(18'h00123, 0);
        m_active = 1'b1; m_addr0 = 1'b1; t0 = cyc;
        bus.Start = 1'b1; bus.Start_address = 18'h00123; bus.Word_count = '0;
        @(posedge clk); #1;
        chk("zero_done_next_cycle", bus.Done, 1);
        bus.Start_address = 18'h00005; bus.Word_count = 18'd1;
        @(posedge clk); #1;
        chk("start_at_done_ignored", bus.Busy, 0);
        m_addr0 = 1'b0;
        base = rx_q.size();
        prepare(18'h00005, 1);
        t0 = cyc;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        wait_done(9000, dur);
        chk("single_duration", dur, 8684);
        exp_b.push_back(8'hA5); exp_b.push_back(8'h5A);
        check_bytes("single", base);

        // Three words across the address wrap.
        base = rx_q.size();
        start_xfer(18'h3FFFE, 3);
        wait_done(27000, dur);
        chk("wrap_duration", dur, 26050);
        for (int i = 1; i <= 6; i++) exp_b.push_back(8'(i));
        check_bytes("wrap", base);

        // Stray Start during data bits must not disturb the transfer.
        sa = 18'($urandom); d = 16'($urandom);
        mem[sa] = d;
        base = rx_q.size();
        start_xfer(sa, 1);
        while (cyc - t0 < 1500) @(posedge clk);
        #1;
        bus.Start = 1'b1; bus.Start_address = sa ^ 18'h2AAAA; bus.Word_count = 18'd2;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        wait_done(9000, dur);
        chk("midstart_duration", dur, 8684);
        exp_b.push_back(d[15:8]); exp_b.push_back(d[7:0]);
        check_bytes("midstart", base);

        // Reset during bit 4 of the first byte (bit forced low so the release is visible).
        sa = 18'($urandom); d = 16'($urandom) & 16'hEFFF;
        mem[sa] = d;
        start_xfer(sa, 1);
        while (cyc - t0 < 2300) @(posedge clk);
        #1;
        chk("pre_reset_tx", bus.UART_TX_O, 0);
        rst = 1'b1; m_active = 1'b0;
        #1;
        chk("async_reset_tx", bus.UART_TX_O, 1);
        chk("async_reset_busy", bus.Busy, 0);
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_addr", bus.SRAM_address, 0);
        mem[18'h00000] = 16'hFF00;
        base = rx_q.size();
        start_xfer(18'h00000, 1);
        wait_done(9000, dur);
        chk("after_reset_duration", dur, 8684);
        exp_b.push_back(8'hFF); exp_b.push_back(8'h00);
        check_bytes("after_reset", base);

        // Random block.
        n  = $urandom_range(1, 2);
        sa = 18'($urandom);
        for (int i = 0; i < n; i++) mem[sa + 18'(i)] = 16'($urandom);
        base = rx_q.size();
        start_xfer(sa, n);
        wait_done(n * P + 100, dur);
        chk("random_duration", dur, n * P + 1);
        for (int i = 0; i < n; i++) begin
            exp_b.push_back(m_data[i][15:8]);
            exp_b.push_back(m_data[i][7:0]);
        end
        check_bytes("random", base);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_uart_transmitter.md
Name: sram_uart_transmitter

Overview:
- Reads a contiguous region of 16-bit words from external SRAM and serialises it out the UART TX pin, high byte first, as 8N1 frames.
- Mirror of the UART-receive/SRAM-fill path: lets the board dump decoded RGB or intermediate data back to the host PC for comparison against .sram_d1/.ppm golden files.
- Sits beside the top-level FSM and owns the SRAM address/we_n mux input while Busy is high.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud).
- READ_LATENCY, 2, rising edges from SRAM_address driven to SRAM_read_data valid.
- ADDR_W, 18, SRAM word-address width.

Ports:
- Clock_50  in  1  system clock, 50 MHz, all logic on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle request; sampled only in S_IDLE.
- Start_address  in  ADDR_W  first word address; latched on accepted Start.
- Word_count  in  ADDR_W  number of words to send; latched on accepted Start.
- SRAM_address  out  ADDR_W  read address.
- SRAM_read_data  in  16  read data from SRAM controller.
- SRAM_we_n  out  1  constant 1 (block never writes).
- UART_TX_O  out  1  serial line, idle high.
- Busy  out  1  high from accepted Start until Done.
- Done  out  1  one-cycle pulse at completion.

Behaviour:
- Reset (async) values: state S_IDLE, UART_TX_O=1, SRAM_address=0, SRAM_we_n=1, Busy=0, Done=0. Clear all counters and shift registers. Reset mid-frame truncates the frame; the line returns high immediately.
- States: S_IDLE, S_READ, S_WAIT, S_TX_START, S_TX_DATA, S_TX_STOP, S_DONE.
- S_IDLE:
  - On Start=1, latch the inputs into addr_reg and words_left and set Busy=1.
  - If Word_count==0, go to S_DONE. Otherwise go to S_READ.
  - Start in any other state is ignored, with no effect on the transfer.
- S_READ: drive SRAM_address=addr_reg for one cycle, then go to S_WAIT.
- S_WAIT:
  - Latch SRAM_read_data into word_buf on the READ_LATENCY-th rising edge after the address was first driven; SRAM_address holds meanwhile.
  - Set byte_sel=0 (high byte) and go to S_TX_START.
  - The line stays high from the end of the last stop bit until the next start bit: READ_LATENCY+1 cycles between words, none between the bytes of one word.
- S_TX_START: UART_TX_O=0 for exactly CLKS_PER_BIT cycles. Load the shifter with word_buf[15:8] if byte_sel=0, else word_buf[7:0].
- S_TX_DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. The bit counter runs 0..7.
- S_TX_STOP: UART_TX_O=1 for CLKS_PER_BIT cycles, then:
  - byte_sel=0: set byte_sel=1 and go to S_TX_START.
  - byte_sel=1, words_left>1: decrement words_left, increment addr_reg, go to S_READ.
  - byte_sel=1, words_left==1: go to S_DONE.
- Address arithmetic is modulo 2^ADDR_W: 18'h3FFFF+1 wraps to 0 and the transfer continues.
- S_DONE: Done=1 for one cycle, Busy=0 the same cycle, return to S_IDLE. A Start coincident with Done is ignored; the next Start is accepted from the following cycle.
- Baud counter: 0..CLKS_PER_BIT-1, reset on every bit boundary. Bit period has no jitter.
- Frame length is 10*CLKS_PER_BIT cycles.
- Total cycles from Start to Done for N≥1 words: N*(1+READ_LATENCY+20*CLKS_PER_BIT)+1.

Test Plan:
- Single word: SRAM[5]=16'hA55A, Start_address=5, Word_count=1.
  - Line decodes bytes 8'hA5 then 8'h5A.
  - Each bit is 434 cycles wide, with 0 cycles of idle between the two bytes.
  - Done pulses 1+2+8680+1 = 8684 cycles after Start; Busy is high throughout.
- Word_count=0 -> Done pulses the cycle after Start. UART_TX_O stays 1, and SRAM_address never changes from 0.
- Multi-word with wrap: Start_address=18'h3FFFE, Word_count=3, data 16'h0102/16'h0304/16'h0506.
  - Addresses issued: 3FFFE, 3FFFF, 00000.
  - Bytes received: 01 02 03 04 05 06, with a 3-cycle idle gap between words.
- Start pulse asserted mid-transfer (during S_TX_DATA of word 0) with different Start_address -> output byte stream and Done timing identical to a run without the pulse.
- Reset asserted mid-frame (bit 4 of first byte) -> UART_TX_O=1 and Busy=0 in the same cycle (asynchronous). After deassertion, a new Start, Start_address=0, Word_count=1 with SRAM[0]=16'hFF00 sends FF,00 correctly.
- Throughout all tests, SRAM_we_n is never 0. Bench checks this via an assertion on every rising edge.
